// File: rtl/pipeline_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_pkg
//  Description : Shared types and constants for the RV32I pipeline control
//                path: controller state encoding, resolved-hazard encoding
//                and the hard-wired zero register index.
//  Revision    : 1.0 - initial release
// ============================================================================
package pipeline_pkg;

    // Index of the hard-wired zero register; writes to it never create data.
    localparam logic [4:0] REG_X0 = 5'd0;

    // Controller state.
    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        ERROR    = 2'd2
    } ctrl_state_t;

    // Hazard selected after priority resolution, highest priority last.
    typedef enum logic [2:0] {
        HZ_NONE      = 3'd0,
        HZ_LOAD_USE  = 3'd1,
        HZ_REDIRECT  = 3'd2,
        HZ_MEM_STALL = 3'd3,
        HZ_ERROR     = 3'd4
    } hazard_e;

endpackage : pipeline_pkg
`default_nettype wire

// File: rtl/load_use_detect.sv
`default_nettype none
// ============================================================================
//  Module      : load_use_detect
//  Description : Purely combinational load-use comparator. Flags when the
//                instruction in ID reads a register that the load in EX has
//                not yet produced. x0 never matches.
//  Ports       : rs1_id, rs2_id         - ID source register indices
//                rs1_used_id/rs2_used_id- ID instruction really reads rs1/rs2
//                rd_ex                  - EX destination register
//                load_ex                - EX instruction is a load
//                load_use               - dependency detected
//  Revision    : 1.0 - initial release
// ============================================================================
module load_use_detect
    import pipeline_pkg::*;
(
    input  logic [4:0] rs1_id,
    input  logic [4:0] rs2_id,
    input  logic       rs1_used_id,
    input  logic       rs2_used_id,
    input  logic [4:0] rd_ex,
    input  logic       load_ex,
    output logic       load_use
);

    logic w_rs1_hit;
    logic w_rs2_hit;

    assign w_rs1_hit = rs1_used_id & (rs1_id == rd_ex);
    assign w_rs2_hit = rs2_used_id & (rs2_id == rd_ex);
    assign load_use  = load_ex & (rd_ex != REG_X0) & (w_rs1_hit | w_rs2_hit);

endmodule : load_use_detect
`default_nettype wire

// File: rtl/pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module      : pipeline_controller
//  Description : Central stall/flush sequencer for the RV32I 5-stage
//                pipeline. Resolves memory stalls, EX redirects and load-use
//                hazards into register enables/flushes, runs a watchdog on
//                memory waits and keeps stall/flush performance counters.
//  Ports       : clk, rst (async, active high)
//                rs1_id, rs2_id, rs1_used_id, rs2_used_id, rd_ex, load_ex
//                                         - load-use inputs
//                redirect_ex              - taken branch / jump in EX
//                dmem_req_mem, dmem_ready - data-memory handshake in MEM
//                pc_en, if_id_en, id_ex_en, ex_mem_en - register enables
//                if_id_flush, id_ex_flush, mem_wb_bubble - NOP insertion
//                mem_error                - sticky watchdog expiry
//                stall_cycles, flush_events - performance counters
//  Revision    : 1.0 - initial release
// ============================================================================
module pipeline_controller
    import pipeline_pkg::*;
#(
    parameter int MEM_TIMEOUT = 16,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic [4:0]       rd_ex,
    input  logic             load_ex,
    input  logic             redirect_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ready,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             id_ex_en,
    output logic             ex_mem_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             mem_wb_bubble,
    output logic             mem_error,
    output logic [CNT_W-1:0] stall_cycles,
    output logic [CNT_W-1:0] flush_events
);

    // Wide enough to hold MEM_TIMEOUT-1 plus saturation headroom.
    localparam int WAIT_W = (MEM_TIMEOUT < 2) ? 1 : $clog2(MEM_TIMEOUT + 1);
    localparam logic [WAIT_W-1:0] c_wait_limit = WAIT_W'((MEM_TIMEOUT < 2) ? 0 : MEM_TIMEOUT - 1);
    localparam logic [WAIT_W-1:0] c_wait_max   = {WAIT_W{1'b1}};
    // With a timeout of one cycle the very first stalled cycle already expires.
    localparam logic c_instant_timeout = (MEM_TIMEOUT < 2);

    ctrl_state_t      r_state_q,  w_state_d;
    logic [WAIT_W-1:0] r_wait_q,  w_wait_d;
    logic              r_err_q,   w_err_d;
    logic [CNT_W-1:0]  r_stall_q, w_stall_d;
    logic [CNT_W-1:0]  r_flush_q, w_flush_d;

    logic              w_mem_stall;
    logic              w_load_use;
    logic [WAIT_W-1:0] w_wait_inc;
    hazard_e           w_hazard;

    load_use_detect u_load_use_detect (
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .rs1_used_id (rs1_used_id),
        .rs2_used_id (rs2_used_id),
        .rd_ex       (rd_ex),
        .load_ex     (load_ex),
        .load_use    (w_load_use)
    );

    assign w_mem_stall = dmem_req_mem & ~dmem_ready;
    assign w_wait_inc  = (r_wait_q == c_wait_max) ? r_wait_q : r_wait_q + 1'b1;

    // Priority resolution: ERROR > mem_stall > redirect > load_use > none.
    always_comb begin
        w_hazard = HZ_NONE;
        if (r_state_q == ERROR) begin
            w_hazard = HZ_ERROR;
        end else if (w_mem_stall) begin
            w_hazard = HZ_MEM_STALL;
        end else if (redirect_ex) begin
            w_hazard = HZ_REDIRECT;
        end else if (w_load_use) begin
            w_hazard = HZ_LOAD_USE;
        end
    end

    // Next-state, watchdog and counters.
    always_comb begin
        w_state_d = r_state_q;
        w_wait_d  = r_wait_q;
        case (r_state_q)
            RUN: begin
                w_wait_d = '0;
                if (w_mem_stall) begin
                    w_state_d = c_instant_timeout ? ERROR : MEM_WAIT;
                end
            end
            MEM_WAIT: begin
                // The RUN cycle that entered MEM_WAIT was the first stalled
                // cycle, so w_wait_inc == MEM_TIMEOUT-1 marks the
                // MEM_TIMEOUT-th consecutive stalled cycle.
                if (w_mem_stall) begin
                    w_wait_d = w_wait_inc;
                    if (w_wait_inc >= c_wait_limit) begin
                        w_state_d = ERROR;
                    end
                end else begin
                    // Access completed (or was withdrawn): this cycle is
                    // already a normal cycle resolved by the lower priorities.
                    w_state_d = RUN;
                    w_wait_d  = '0;
                end
            end
            ERROR: begin
                w_state_d = ERROR;
            end
            default: begin
                w_state_d = RUN;
                w_wait_d  = '0;
            end
        endcase

        w_err_d   = r_err_q | (w_state_d == ERROR);
        w_stall_d = r_stall_q;
        w_flush_d = r_flush_q;
        if ((w_hazard == HZ_MEM_STALL) || (w_hazard == HZ_LOAD_USE)) begin
            w_stall_d = r_stall_q + 1'b1;
        end
        if (w_hazard == HZ_REDIRECT) begin
            w_flush_d = r_flush_q + 1'b1;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state_q <= RUN;
            r_wait_q  <= '0;
            r_err_q   <= 1'b0;
            r_stall_q <= '0;
            r_flush_q <= '0;
        end else begin
            r_state_q <= w_state_d;
            r_wait_q  <= w_wait_d;
            r_err_q   <= w_err_d;
            r_stall_q <= w_stall_d;
            r_flush_q <= w_flush_d;
        end
    end

    // Output decode. While rst is held the pipeline runs freely so that the
    // reset state flows through every stage register.
    always_comb begin
        pc_en         = 1'b1;
        if_id_en      = 1'b1;
        id_ex_en      = 1'b1;
        ex_mem_en     = 1'b1;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        mem_wb_bubble = 1'b0;
        if (!rst) begin
            case (w_hazard)
                HZ_ERROR: begin
                    pc_en     = 1'b0;
                    if_id_en  = 1'b0;
                    id_ex_en  = 1'b0;
                    ex_mem_en = 1'b0;
                end
                HZ_MEM_STALL: begin
                    pc_en         = 1'b0;
                    if_id_en      = 1'b0;
                    id_ex_en      = 1'b0;
                    ex_mem_en     = 1'b0;
                    mem_wb_bubble = 1'b1;
                end
                HZ_REDIRECT: begin
                    if_id_flush = 1'b1;
                    id_ex_flush = 1'b1;
                end
                HZ_LOAD_USE: begin
                    // Hold PC and IF/ID, drop a bubble into ID/EX, let the
                    // load advance: exactly one cycle lost.
                    pc_en       = 1'b0;
                    if_id_en    = 1'b0;
                    id_ex_flush = 1'b1;
                end
                default: begin
                    pc_en = 1'b1;
                end
            endcase
        end
    end

    assign mem_error    = r_err_q;
    assign stall_cycles = r_stall_q;
    assign flush_events = r_flush_q;

endmodule : pipeline_controller
`default_nettype wire

// File: tb/tb_pipeline_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_pipeline_controller
//  Description : Directed self-checking bench for pipeline_controller.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_pipeline_controller;

    localparam int CNT_W = 32;

    // Control vector: {pc_en, if_id_en, id_ex_en, ex_mem_en,
    //                  if_id_flush, id_ex_flush, mem_wb_bubble}
    localparam logic [6:0] c_none  = 7'b1111_000;
    localparam logic [6:0] c_lu    = 7'b0011_010;
    localparam logic [6:0] c_redir = 7'b1111_110;
    localparam logic [6:0] c_mems  = 7'b0000_001;
    localparam logic [6:0] c_err   = 7'b0000_000;

    logic clk = 1'b0;
    logic rst;
    logic [4:0] rs1_id, rs2_id, rd_ex;
    logic rs1_used_id, rs2_used_id, load_ex, redirect_ex, dmem_req_mem, dmem_ready;
    logic pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble;
    logic mem_error;
    logic [CNT_W-1:0] stall_cycles, flush_events;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    pipeline_controller #(
        .MEM_TIMEOUT (4),
        .CNT_W       (CNT_W)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .rs1_id        (rs1_id),
        .rs2_id        (rs2_id),
        .rs1_used_id   (rs1_used_id),
        .rs2_used_id   (rs2_used_id),
        .rd_ex         (rd_ex),
        .load_ex       (load_ex),
        .redirect_ex   (redirect_ex),
        .dmem_req_mem  (dmem_req_mem),
        .dmem_ready    (dmem_ready),
        .pc_en         (pc_en),
        .if_id_en      (if_id_en),
        .id_ex_en      (id_ex_en),
        .ex_mem_en     (ex_mem_en),
        .if_id_flush   (if_id_flush),
        .id_ex_flush   (id_ex_flush),
        .mem_wb_bubble (mem_wb_bubble),
        .mem_error     (mem_error),
        .stall_cycles  (stall_cycles),
        .flush_events  (flush_events)
    );

    logic [6:0] ctl;
    assign ctl = {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_flush, id_ex_flush, mem_wb_bubble};

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic idle_inputs();
        rs1_id = 5'd0; rs2_id = 5'd0; rd_ex = 5'd0;
        rs1_used_id = 1'b0; rs2_used_id = 1'b0; load_ex = 1'b0;
        redirect_ex = 1'b0; dmem_req_mem = 1'b0; dmem_ready = 1'b0;
    endtask

    // Advance to just after the next rising edge (input drive point).
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Move to the sampling point half a cycle away from the edge.
    task automatic settle();
        @(negedge clk);
    endtask

    initial begin
        rst = 1'b1;
        idle_inputs();
        #2;
        chk("rst_ctl", 32'(ctl), 32'(c_none));
        chk("rst_err", 32'(mem_error), 32'd0);
        chk("rst_stall", stall_cycles, 32'd0);
        chk("rst_flush", flush_events, 32'd0);
        #10 rst = 1'b0;                         // released between edges
        tick();
        settle();
        chk("idle_ctl", 32'(ctl), 32'(c_none));

        // Load-use on rs1.
        tick();
        load_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
        settle();
        chk("lu_rs1_ctl", 32'(ctl), 32'(c_lu));
        tick();
        idle_inputs();
        settle();
        chk("lu_one_cycle", 32'(ctl), 32'(c_none));
        chk("lu_stall_cnt", stall_cycles, 32'd1);

        // x0 destination never stalls.
        tick();
        load_ex = 1'b1; rd_ex = 5'd0; rs1_id = 5'd0; rs1_used_id = 1'b1;
        settle();
        chk("x0_ctl", 32'(ctl), 32'(c_none));

        // Load-use on rs2, then same registers with rs2 unused.
        tick();
        idle_inputs();
        load_ex = 1'b1; rd_ex = 5'd7; rs2_id = 5'd7; rs2_used_id = 1'b1; rs1_id = 5'd7;
        settle();
        chk("lu_rs2_ctl", 32'(ctl), 32'(c_lu));
        tick();
        rs2_used_id = 1'b0;
        settle();
        chk("rs_unused_ctl", 32'(ctl), 32'(c_none));
        chk("stall_after_x0", stall_cycles, 32'd2);

        // Redirect together with a load-use match.
        tick();
        idle_inputs();
        redirect_ex = 1'b1; load_ex = 1'b1; rd_ex = 5'd5; rs1_id = 5'd5; rs1_used_id = 1'b1;
        settle();
        chk("redir_lu_ctl", 32'(ctl), 32'(c_redir));
        tick();
        idle_inputs();
        settle();
        chk("redir_flush_cnt", flush_events, 32'd1);
        chk("redir_stall_cnt", stall_cycles, 32'd2);

        // Memory wait of 3 cycles with a redirect pending throughout.
        tick();
        redirect_ex = 1'b1; dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        settle();
        chk("mw_c1", 32'(ctl), 32'(c_mems));
        tick();
        settle();
        chk("mw_c2", 32'(ctl), 32'(c_mems));
        tick();
        settle();
        chk("mw_c3", 32'(ctl), 32'(c_mems));
        tick();
        dmem_ready = 1'b1;
        settle();
        chk("mw_c4_redir", 32'(ctl), 32'(c_redir));
        tick();
        idle_inputs();
        settle();
        chk("mw_stall_cnt", stall_cycles, 32'd5);
        chk("mw_flush_cnt", flush_events, 32'd2);
        chk("mw_no_err", 32'(mem_error), 32'd0);

        // Watchdog: 4 consecutive stalled cycles with MEM_TIMEOUT = 4.
        tick();
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        settle();
        chk("wd_c1", 32'(ctl), 32'(c_mems));
        tick();
        settle();
        chk("wd_c2", 32'(ctl), 32'(c_mems));
        tick();
        settle();
        chk("wd_c3", 32'(ctl), 32'(c_mems));
        tick();
        settle();
        chk("wd_c4", 32'(ctl), 32'(c_mems));
        chk("wd_c4_err_low", 32'(mem_error), 32'd0);
        tick();
        dmem_ready = 1'b1; redirect_ex = 1'b1;
        settle();
        chk("wd_err_ctl", 32'(ctl), 32'(c_err));
        chk("wd_err_flag", 32'(mem_error), 32'd1);
        chk("wd_stall_cnt", stall_cycles, 32'd9);
        tick();
        settle();
        chk("wd_err_hold", 32'(ctl), 32'(c_err));
        chk("wd_flush_hold", flush_events, 32'd2);

        // Reset pulse out of ERROR, between edges.
        #2 rst = 1'b1;
        #1;
        chk("wd_rst_ctl", 32'(ctl), 32'(c_none));
        chk("wd_rst_err", 32'(mem_error), 32'd0);
        chk("wd_rst_stall", stall_cycles, 32'd0);
        chk("wd_rst_flush", flush_events, 32'd0);
        idle_inputs();
        #1 rst = 1'b0;
        tick();
        settle();
        chk("post_rst_ctl", 32'(ctl), 32'(c_none));

        // Asynchronous reset in the middle of a memory wait.
        tick();
        dmem_req_mem = 1'b1; dmem_ready = 1'b0;
        settle();
        chk("ar_c1", 32'(ctl), 32'(c_mems));
        tick();
        chk("ar_stall_pre", stall_cycles, 32'd1);
        #2 rst = 1'b1;
        #1;
        chk("ar_ctl", 32'(ctl), 32'(c_none));
        chk("ar_stall", stall_cycles, 32'd0);
        #1 rst = 1'b0;
        settle();
        chk("ar_run_again", 32'(ctl), 32'(c_mems));
        idle_inputs();
        tick();
        settle();
        chk("ar_final", 32'(ctl), 32'(c_none));
        chk("ar_final_err", 32'(mem_error), 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule : tb_pipeline_controller
`default_nettype wire

// File: doc/pipeline_controller.md
# pipeline_controller

Central stall/flush sequencer for the RV32I 5-stage pipeline. Drives the enable and flush controls of the PC, IF/ID, ID/EX, EX/MEM and MEM/WB registers from three hazard sources:
- load-use dependencies between ID and EX;
- taken branches and jumps resolved in EX;
- multi-cycle data-memory accesses in MEM.

It also keeps a watchdog on memory waits and holds performance counters for stall and flush cycles.

## Interface
Parameters:
- MEM_TIMEOUT, 16: consecutive memory-wait cycles tolerated before the controller enters ERROR.
- CNT_W, 32: width of the performance counters.

Ports:
- clk  in  1  pipeline clock; all state updates on the rising edge.
- rst  in  1  asynchronous, active-high reset.
- rs1_id, rs2_id  in  5 each  source register indices of the instruction in ID.
- rs1_used_id, rs2_used_id  in  1 each  the ID instruction actually reads rs1 / rs2.
- rd_ex  in  5  destination register of the instruction in EX.
- load_ex  in  1  the EX instruction is a load.
- redirect_ex  in  1  EX resolved a taken branch or a jump (next_pc_selector ≠ PC+4).
- dmem_req_mem  in  1  MEM stage is issuing a load or store.
- dmem_ready  in  1  data memory completes the access this cycle.
- pc_en, if_id_en, id_ex_en, ex_mem_en  out  1 each  register load enables.
- if_id_flush, id_ex_flush, mem_wb_bubble  out  1 each  insert a NOP into that register.
- mem_error  out  1  sticky; the memory watchdog expired.
- stall_cycles, flush_events  out  CNT_W each  performance counters.

## Operation
States are RUN, MEM_WAIT and ERROR.

Hazard conditions, evaluated every cycle:
- mem_stall = dmem_req_mem & ~dmem_ready.
- load_use = load_ex & (rd_ex ≠ 0) & ((rs1_used_id & rs1_id == rd_ex) | (rs2_used_id & rs2_id == rd_ex)).
- Register x0 never causes a hazard.

Resolution priority: ERROR > mem_stall > redirect_ex > load_use > none.
- **ERROR**: all enables 0, all flushes 0; the pipeline is frozen until reset.
- **mem_stall**: all enables 0, mem_wb_bubble = 1, other flushes 0.
  - A redirect_ex or load_use present in the same cycle is not acted on. The frozen EX stage re-presents it once the stall clears.
- **redirect_ex**: all enables 1, if_id_flush = 1, id_ex_flush = 1.
  - The PC loads the target.
  - A simultaneous load_use is discarded, because the dependent instruction is being flushed anyway.
- **load_use**: pc_en = 0, if_id_en = 0, id_ex_flush = 1, ex_mem_en = 1.
  - This inserts exactly one bubble per occurrence.
- **none**: all enables 1, all flushes 0.

State transitions:
- RUN → MEM_WAIT on mem_stall.
- MEM_WAIT → RUN when dmem_ready = 1. The completing cycle is a normal cycle and is evaluated against the lower priorities.
- MEM_WAIT → ERROR when the wait counter reaches MEM_TIMEOUT−1 and mem_stall is still true.
- ERROR is left only by rst.

Wait counter:
- Cleared in RUN.
- Incremented each MEM_WAIT cycle in which mem_stall holds.
- Saturates; it never wraps.

Performance counters:
- stall_cycles increments on every mem_stall or load_use cycle, including ERROR-free MEM_WAIT cycles.
- flush_events increments once per cycle in which redirect_ex is acted on.
- Both wrap modulo 2^CNT_W.

## Timing
- Enables and flushes are combinational from the inputs and the current state. They take effect at the next rising edge, with zero added latency.
- State, wait counter, mem_error and the performance counters are registered.
- Reset values: state = RUN, wait counter = 0, mem_error = 0, stall_cycles = 0, flush_events = 0.
- During rst, enable outputs are 1 and flush outputs are 0.
- A load-use stall costs exactly 1 cycle. A taken redirect costs 2 squashed instructions.
- A memory wait of N cycles (dmem_ready low for N cycles, then high) freezes the pipeline for exactly N cycles.
- ERROR is entered on the edge ending the MEM_TIMEOUT-th consecutive stalled cycle. mem_error is high from the next cycle onward.
- A reset asserted mid-stall or in ERROR returns to RUN asynchronously and clears all counters.

## Structure
- pipeline_pkg holds:
  - ctrl_state_t, the enum {RUN, MEM_WAIT, ERROR};
  - the REG_X0 constant;
  - a hazard_e enum for the resolved priority.
- Sub-module load_use_detect is the purely combinational comparator that produces load_use. It is reused by future forwarding logic.
- pipeline_controller contains the FSM, the watchdog, the counters and the output decode.

## Test plan
- **Load-use hazard**: load_ex=1, rd_ex=5, rs1_id=5, rs1_used_id=1 for 1 cycle → pc_en=0, if_id_en=0, id_ex_flush=1 for exactly that cycle; stall_cycles 0→1.
- **x0 destination**: load_ex=1, rd_ex=0, rs1_id=0, rs1_used_id=1 → no stall; all enables 1.
- **Redirect plus load-use**: redirect_ex=1 together with a load_use match → if_id_flush=1, id_ex_flush=1, pc_en=1; flush_events 0→1; stall_cycles unchanged.
- **Memory wait**: dmem_req_mem=1, dmem_ready=0 for 3 cycles then 1, with redirect_ex=1 throughout → enables 0 and mem_wb_bubble=1 for 3 cycles, then flushes on cycle 4; stall_cycles=3.
- **Watchdog**: MEM_TIMEOUT=4, dmem_ready held 0 for 4 cycles → state ERROR, mem_error=1, all enables 0 even after dmem_ready=1; rst pulse → RUN, counters 0.
- **Async reset mid-stall**: rst asserted between edges during MEM_WAIT → outputs take reset values immediately, without waiting for a clock edge.
